// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - sequencer <-> fetch/execute datapath control bundle
interface cpu_sequencer_if;
   logic        start;
   logic        halt_req;
   logic        cond_ok;
   logic [31:0] ir;
   logic        mem_ack;
   logic        write_ir;
   logic        write_pc;
   logic [1:0]  pc_s;
   logic        write_reg;
   logic        lr_sel;
   logic        reg_src_mem;
   logic        write_nzcv;
   logic        mem_req;
   logic        mem_we;

   modport master (
      input  start, halt_req, cond_ok, ir, mem_ack,
      output write_ir, write_pc, pc_s, write_reg, lr_sel, reg_src_mem,
             write_nzcv, mem_req, mem_we
   );

   modport slave (
      output start, halt_req, cond_ok, ir, mem_ack,
      input  write_ir, write_pc, pc_s, write_reg, lr_sel, reg_src_mem,
             write_nzcv, mem_req, mem_we
   );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle control FSM with retired-instruction counter
module cpu_sequencer #(
   parameter int RETIRE_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   cpu_sequencer_if.master     bus,
   output logic                busy,
   output logic                trap,
   output logic [2:0]          state,
   output logic [RETIRE_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_MEM    = 3'd5,
      S_BRANCH = 3'd6,
      S_TRAP   = 3'd7
   } state_t;

   state_t                state_q, state_d;
   state_t                boundary_st;
   logic [RETIRE_W-1:0]   retired_q, retired_d;
   logic                  retire;
   logic [1:0]            op;
   logic                  s_bit;

   assign op          = bus.ir[27:26];
   assign s_bit       = bus.ir[20];
   // halt_req only matters on transitions that would otherwise re-enter FETCH
   assign boundary_st = bus.halt_req ? S_IDLE : S_FETCH;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_IDLE:   if (bus.start && !bus.halt_req) state_d = S_FETCH;
         S_FETCH:  state_d = bus.cond_ok ? S_DECODE : boundary_st;
         S_DECODE: begin
            case (op)
               2'b00:   state_d = S_EXEC;
               2'b01:   state_d = S_MEM;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_TRAP;
            endcase
         end
         S_EXEC:   state_d = S_WB;
         S_WB: begin
            retire  = 1'b1;
            state_d = boundary_st;
         end
         S_MEM: begin
            if (bus.mem_ack) begin
               if (s_bit) begin
                  state_d = S_WB;
               end else begin
                  retire  = 1'b1;
                  state_d = boundary_st;
               end
            end
         end
         S_BRANCH: begin
            retire  = 1'b1;
            state_d = boundary_st;
         end
         default:  state_d = S_TRAP;
      endcase
      retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, retire};
   end

   always_comb begin
      bus.write_ir    = 1'b0;
      bus.write_pc    = 1'b0;
      bus.pc_s        = 2'b00;
      bus.write_reg   = 1'b0;
      bus.lr_sel      = 1'b0;
      bus.reg_src_mem = 1'b0;
      bus.write_nzcv  = 1'b0;
      bus.mem_req     = 1'b0;
      bus.mem_we      = 1'b0;
      case (state_q)
         S_FETCH: begin
            bus.write_ir = 1'b1;
            bus.write_pc = 1'b1;
         end
         S_EXEC:   bus.write_nzcv = s_bit;
         S_WB: begin
            bus.write_reg   = 1'b1;
            bus.reg_src_mem = (op == 2'b01) && s_bit;
         end
         S_MEM: begin
            bus.mem_req = 1'b1;
            bus.mem_we  = ~s_bit;
         end
         S_BRANCH: begin
            bus.write_pc  = 1'b1;
            bus.pc_s      = bus.ir[25] ? 2'b10 : 2'b01;
            bus.write_reg = bus.ir[24];
            bus.lr_sel    = bus.ir[24];
         end
         default: ;
      endcase
   end

   assign state   = state_q;
   assign busy    = (state_q != S_IDLE) && (state_q != S_TRAP);
   assign trap    = (state_q == S_TRAP);
   assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        busy, trap, busy4, trap4;
   logic [2:0]  state, state4;
   logic [15:0] retired;
   logic [3:0]  retired4;

   int n_checks = 0;
   int n_fail = 0;
   int model_retired = 0;

   cpu_sequencer_if bus ();
   cpu_sequencer_if bus4 ();

   assign bus4.start    = bus.start;
   assign bus4.halt_req = bus.halt_req;
   assign bus4.cond_ok  = bus.cond_ok;
   assign bus4.ir       = bus.ir;
   assign bus4.mem_ack  = bus.mem_ack;

   cpu_sequencer #(.RETIRE_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.master),
      .busy(busy), .trap(trap), .state(state), .retired(retired)
   );

   cpu_sequencer #(.RETIRE_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4.master),
      .busy(busy4), .trap(trap4), .state(state4), .retired(retired4)
   );

   always #5 clk = ~clk;

   // Control outputs required in each state, straight from the state table
   function automatic logic [11:0] exp_out(input int st, input logic [31:0] iw);
      logic wir, wpc, wreg, lr, rsm, nzcv, mreq, mwe, bsy, trp;
      logic [1:0] pcs;
      {wir, wpc, wreg, lr, rsm, nzcv, mreq, mwe, bsy, trp} = '0;
      pcs = 2'b00;
      case (st)
         1: begin wir = 1; wpc = 1; end
         3: nzcv = iw[20];
         4: begin wreg = 1; rsm = (iw[27:26] == 2'b01) && iw[20]; end
         5: begin mreq = 1; mwe = ~iw[20]; end
         6: begin wpc = 1; pcs = iw[25] ? 2'b10 : 2'b01; wreg = iw[24]; lr = iw[24]; end
         7: trp = 1;
         default: ;
      endcase
      bsy = (st != 0) && (st != 7);
      return {wir, wpc, pcs, wreg, lr, rsm, nzcv, mreq, mwe, bsy, trp};
   endfunction

   function automatic logic [11:0] got_out();
      return {bus.write_ir, bus.write_pc, bus.pc_s, bus.write_reg, bus.lr_sel,
              bus.reg_src_mem, bus.write_nzcv, bus.mem_req, bus.mem_we, busy, trap};
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.start = 0; bus.halt_req = 0; bus.cond_ok = 0; bus.ir = '0; bus.mem_ack = 0;
      #1;
      n_checks++;
      if (state !== 3'd0 || got_out() !== 12'h0 || retired !== 16'h0 || retired4 !== 4'h0) begin
         n_fail++;
         $display("FAIL reset: state=%0d outs=%h retired=%0d/%0d, want 0", state, got_out(), retired, retired4);
      end
      model_retired = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // From IDLE at a falling edge; leaves the DUT in FETCH at a falling edge
   task automatic start_run();
      bus.start = 1; bus.halt_req = 1;
      @(negedge clk);
      n_checks++;
      if (state !== 3'd0) begin
         n_fail++;
         $display("FAIL start_blocked_by_halt: state=%0d want 0", state);
      end
      bus.halt_req = 0;
      @(negedge clk);
      n_checks++;
      if (state !== 3'd1) begin
         n_fail++;
         $display("FAIL start_to_fetch: state=%0d want 1", state);
      end
      bus.start = 0;
   endtask

   // One instruction from FETCH entry to the next boundary, traced cycle by cycle
   task automatic run_instr(input logic [31:0] iw, input bit cond, input int waits,
                            input bit halt, input bit hold_halt);
      int seq[$];
      int memk;
      int st;
      bit last;
      seq = {1};
      if (cond) begin
         seq.push_back(2);
         case (iw[27:26])
            2'b00: seq = {seq, 3, 4};
            2'b01: begin
               for (int k = 0; k <= waits; k++) seq.push_back(5);
               if (iw[20]) seq.push_back(4);
            end
            default: seq.push_back(6);
         endcase
      end
      memk = 0;
      for (int i = 0; i < seq.size(); i++) begin
         st = seq[i];
         last = (i == seq.size() - 1);
         n_checks++;
         if (state !== 3'(st)) begin
            n_fail++;
            $display("FAIL trace_state[%0d] ir=%h: state=%0d want %0d", i, iw, state, st);
         end
         n_checks++;
         if (got_out() !== exp_out(st, iw)) begin
            n_fail++;
            $display("FAIL trace_outs[%0d] st=%0d ir=%h: outs=%h want %h", i, st, iw, got_out(), exp_out(st, iw));
         end
         bus.ir = iw;
         bus.cond_ok = (st == 1) ? cond : 1'($urandom);
         if (st == 5) begin
            bus.mem_ack = (memk == waits);
            memk++;
         end else begin
            bus.mem_ack = 1'($urandom);
         end
         bus.start = 1'($urandom);
         bus.halt_req = last ? halt : (hold_halt ? 1'b1 : 1'($urandom));
         @(negedge clk);
      end
      if (cond) model_retired++;
      n_checks++;
      if (state !== (halt ? 3'd0 : 3'd1) || busy !== !halt) begin
         n_fail++;
         $display("FAIL boundary ir=%h: state=%0d busy=%b want state %0d", iw, state, busy, halt ? 0 : 1);
      end
      n_checks++;
      if (retired !== 16'(model_retired) || retired4 !== 4'(model_retired)) begin
         n_fail++;
         $display("FAIL retired ir=%h: got %0d/%0d want %0d", iw, retired, retired4, model_retired);
      end
      bus.start = 0; bus.halt_req = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if (trap !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: trap=%b busy=%b want 0 0", trap, busy);
      end
   endtask

   task automatic test_dp();
      start_run();
      run_instr(32'hE0812003, 1, 0, 0, 0);
      n_checks++;
      if (retired !== 16'd1) begin
         n_fail++;
         $display("FAIL dp_retired: got %0d want 1", retired);
      end
   endtask

   task automatic test_load();
      run_instr(32'hE5912000, 1, 2, 0, 0);
   endtask

   task automatic test_condfail_branch();
      run_instr(32'hE0000000, 0, 0, 0, 0);
      run_instr(32'hEB000010, 1, 0, 0, 0);
   endtask

   task automatic test_halt_mem();
      run_instr(32'hE5812000, 1, 3, 1, 1);
   endtask

   task automatic test_random();
      logic [31:0] iw;
      int cls;
      bit halt;
      start_run();
      for (int n = 0; n < 60; n++) begin
         iw = $urandom;
         cls = $urandom_range(0, 3);
         iw[27:26] = (cls == 3) ? 2'b00 : 2'(cls);
         halt = ($urandom_range(0, 7) == 0);
         run_instr(iw, cls != 3 && $urandom_range(0, 4) != 0, $urandom_range(0, 3), halt, 0);
         if (halt) start_run();
      end
   endtask

   task automatic test_mem_reset();
      apply_reset();
      start_run();
      bus.ir = 32'hE5800000; bus.cond_ok = 1; bus.mem_ack = 0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (state !== 3'd5 || bus.mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL mem_reset_pre: state=%0d mem_req=%b want 5 1", state, bus.mem_req);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (state !== 3'd0 || bus.mem_req !== 1'b0 || got_out() !== 12'h0) begin
         n_fail++;
         $display("FAIL mem_reset_async: state=%0d mem_req=%b want 0 0", state, bus.mem_req);
      end
      model_retired = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_trap();
      start_run();
      bus.ir = 32'hEC000000; bus.cond_ok = 1;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (state !== 3'd7 || got_out() !== exp_out(7, bus.ir) || retired !== 16'(model_retired)) begin
            n_fail++;
            $display("FAIL trap_hold[%0d]: state=%0d outs=%h retired=%0d want 7 %h %0d",
                     i, state, got_out(), retired, exp_out(7, bus.ir), model_retired);
         end
         bus.start = 1'($urandom); bus.halt_req = 1'($urandom); bus.mem_ack = 1'($urandom);
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (trap !== 1'b0 || state !== 3'd0) begin
         n_fail++;
         $display("FAIL trap_clear: trap=%b state=%0d want 0 0", trap, state);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.start = 0; bus.halt_req = 0;
      model_retired = 0;
   endtask

   task automatic test_counter_wrap();
      apply_reset();
      start_run();
      for (int n = 0; n < 17; n++) run_instr(32'hE0812003, 1, 0, n == 16, 0);
      n_checks++;
      if (retired4 !== 4'd1 || retired !== 16'd17) begin
         n_fail++;
         $display("FAIL counter_wrap: retired4=%0d retired=%0d want 1 17", retired4, retired);
      end
   endtask

   initial begin
      test_reset();
      test_dp();
      test_load();
      test_condfail_branch();
      test_halt_mem();
      test_random();
      test_mem_reset();
      test_trap();
      test_counter_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
